// File: rtl/wt_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// wt_mem_arbiter_if
// Downstream memory channel between the write-through memory arbiter and the
// memory side. It carries one registered request channel (valid/ready) and a
// return channel that the arbiter cannot backpressure.
//
// Signals (direction seen from the arbiter):
//   mem_req_valid_o   out  request valid
//   mem_req_ready_i   in   request ready
//   mem_req_data_o    out  request payload (ReqWidth)
//   mem_req_id_o      out  {port index, client tid} (IdW)
//   mem_rtrn_valid_i  in   return valid, no backpressure
//   mem_rtrn_id_i     in   return id {port index, client tid} (IdW)
//   mem_rtrn_data_i   in   return payload (RtrnWidth)
//
// Modports: master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface wt_mem_arbiter_if #(
  parameter int ReqWidth  = 128,
  parameter int RtrnWidth = 128,
  parameter int IdW       = 3
);
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [ReqWidth-1:0]  mem_req_data_o;
  logic [IdW-1:0]       mem_req_id_o;
  logic                 mem_rtrn_valid_i;
  logic [IdW-1:0]       mem_rtrn_id_i;
  logic [RtrnWidth-1:0] mem_rtrn_data_i;

  modport master (
    output mem_req_valid_o,
    output mem_req_data_o,
    output mem_req_id_o,
    input  mem_req_ready_i,
    input  mem_rtrn_valid_i,
    input  mem_rtrn_id_i,
    input  mem_rtrn_data_i
  );

  modport slave (
    input  mem_req_valid_o,
    input  mem_req_data_o,
    input  mem_req_id_o,
    output mem_req_ready_i,
    output mem_rtrn_valid_i,
    output mem_rtrn_id_i,
    output mem_rtrn_data_i
  );
endinterface

// File: rtl/wt_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wt_mem_arbiter
// N-client memory-side arbiter for the write-through cache subsystem. Client
// requests are merged into one single-entry registered downstream request
// channel, tagged with the originating port index. Return beats are routed
// back to the client named by the tag, and each client is limited to
// MaxOutstanding in-flight transactions.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_req_i      per-port request, held until acked
//   data_ack_o      per-port single-cycle acknowledge (combinational)
//   data_i, tid_i   per-port payload and client-local transaction id
//   rtrn_vld_o      per-port return valid (combinational on the return)
//   rtrn_o          return payload, broadcast to all ports
//   rtrn_tid_o      client-local id of the return
//   port_idle_o     per-port flag, no transactions outstanding
//   mem             downstream channel (wt_mem_arbiter_if.master)
//   err_o           sticky flag: return to an unknown port or an idle port
// ---------------------------------------------------------------------------
module wt_mem_arbiter #(
  parameter  int NumPorts       = 2,
  parameter  int ReqWidth       = 128,
  parameter  int RtrnWidth      = 128,
  parameter  int TidWidth       = 2,
  parameter  int MaxOutstanding = 4,
  parameter  int FixedPrio      = 0,
  localparam int IdxW           = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int IdW            = IdxW + TidWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumPorts-1:0]          data_req_i,
  output logic [NumPorts-1:0]          data_ack_o,
  input  logic [NumPorts*ReqWidth-1:0] data_i,
  input  logic [NumPorts*TidWidth-1:0] tid_i,
  output logic [NumPorts-1:0]          rtrn_vld_o,
  output logic [RtrnWidth-1:0]         rtrn_o,
  output logic [TidWidth-1:0]          rtrn_tid_o,
  output logic [NumPorts-1:0]          port_idle_o,
  wt_mem_arbiter_if.master             mem,
  output logic                         err_o
);

  localparam int              CntW     = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastPort = IdxW'(NumPorts - 1);

  logic [NumPorts-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]               rr_q, rr_d;
  logic                          valid_q, valid_d;
  logic [ReqWidth-1:0]           data_q, data_d;
  logic [IdW-1:0]                id_q, id_d;
  logic                          err_q, err_d;

  logic [NumPorts-1:0] eligible;
  logic                can_load;
  logic                grant_found;
  logic                grant_en;
  logic [IdxW-1:0]     grant_idx;
  int                  rr_cand;
  logic [IdxW-1:0]     rtrn_port;
  logic                rtrn_ok;

  // A port competes only while it still has a free credit.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = data_req_i[p] && (cnt_q[p] < MaxCnt);
    end
  end

  // The register may refill when empty or when it is draining this cycle.
  assign can_load = !valid_q || mem.mem_req_ready_i;

  // Winner selection. Round-robin starts one past the last winner and wraps;
  // fixed priority scans downwards so the lowest eligible index is kept last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = 0;
    if (FixedPrio != 0) begin
      for (int k = NumPorts - 1; k >= 0; k--) begin
        if (eligible[k]) begin
          grant_found = 1'b1;
          grant_idx   = IdxW'(k);
        end
      end
    end else begin
      for (int k = 1; k <= NumPorts; k++) begin
        rr_cand = int'(rr_q) + k;
        if (rr_cand >= NumPorts) begin
          rr_cand = rr_cand - NumPorts;
        end
        if (!grant_found && eligible[rr_cand]) begin
          grant_found = 1'b1;
          grant_idx   = IdxW'(rr_cand);
        end
      end
    end
  end

  // Acks are gated by reset so that asserting rst_ni mid-burst silences the
  // client interface immediately, even while requests are still held high.
  assign grant_en = rst_ni && can_load && grant_found;

  always_comb begin
    data_ack_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      data_ack_o[p] = grant_en && (grant_idx == IdxW'(p));
    end
  end

  // Return routing. A return is accepted only for an existing port that has
  // something outstanding; anything else is a protocol error and is dropped.
  assign rtrn_port = mem.mem_rtrn_id_i[IdW-1:TidWidth];

  always_comb begin
    rtrn_ok    = 1'b0;
    rtrn_vld_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (rst_ni && mem.mem_rtrn_valid_i && (rtrn_port == IdxW'(p)) && (cnt_q[p] != '0)) begin
        rtrn_ok       = 1'b1;
        rtrn_vld_o[p] = 1'b1;
      end
    end
  end

  assign rtrn_o     = mem.mem_rtrn_data_i;
  assign rtrn_tid_o = mem.mem_rtrn_id_i[TidWidth-1:0];

  // Credit counters: an ack takes a credit, an accepted return gives one
  // back; both together cancel. Grants stop at the limit so no overflow.
  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < NumPorts; p++) begin
      case ({data_ack_o[p], rtrn_vld_o[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CntW'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CntW'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  // Output register: a grant overwrites it (also when it drains in the same
  // cycle, giving one request per cycle); otherwise it holds until ready.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    rr_d    = rr_q;
    if (grant_en) begin
      valid_d = 1'b1;
      rr_d    = grant_idx;
      for (int p = 0; p < NumPorts; p++) begin
        if (grant_idx == IdxW'(p)) begin
          data_d = data_i[p*ReqWidth +: ReqWidth];
          id_d   = {grant_idx, tid_i[p*TidWidth +: TidWidth]};
        end
      end
    end else if (mem.mem_req_ready_i) begin
      valid_d = 1'b0;
    end
    err_d = err_q || (mem.mem_rtrn_valid_i && !rtrn_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      rr_q    <= LastPort;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    port_idle_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_idle_o[p] = (cnt_q[p] == '0);
    end
  end

  assign mem.mem_req_valid_o = valid_q;
  assign mem.mem_req_data_o  = data_q;
  assign mem.mem_req_id_o    = id_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wt_mem_arbiter
// Directed scenarios followed by a randomized phase. A transaction-level
// model (credits per port, last winner, pending request, sticky error)
// predicts acks, return routing and the downstream register every cycle.
// ---------------------------------------------------------------------------
module tb_wt_mem_arbiter;
  localparam int NP   = 3;
  localparam int RW   = 16;
  localparam int RTW  = 16;
  localparam int TW   = 2;
  localparam int MAXO = 4;
  localparam int IDXW = 2;
  localparam int IDW  = IDXW + TW;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [NP-1:0]    data_req;
  logic [NP-1:0]    data_ack;
  logic [NP*RW-1:0] data;
  logic [NP*TW-1:0] tid;
  logic [NP-1:0]    rtrn_vld;
  logic [RTW-1:0]   rtrn;
  logic [TW-1:0]    rtrn_tid;
  logic [NP-1:0]    port_idle;
  logic             err;

  wt_mem_arbiter_if #(.ReqWidth(RW), .RtrnWidth(RTW), .IdW(IDW)) bus();

  wt_mem_arbiter #(
    .NumPorts(NP), .ReqWidth(RW), .RtrnWidth(RTW), .TidWidth(TW),
    .MaxOutstanding(MAXO), .FixedPrio(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(data_req), .data_ack_o(data_ack),
    .data_i(data), .tid_i(tid),
    .rtrn_vld_o(rtrn_vld), .rtrn_o(rtrn), .rtrn_tid_o(rtrn_tid),
    .port_idle_o(port_idle), .mem(bus), .err_o(err)
  );

  always #5 clk = ~clk;

  int             n_cmp  = 0;
  int             n_fail = 0;
  int             m_cnt[NP];
  int             m_rr;
  bit             m_valid;
  logic [RW-1:0]  m_data;
  logic [IDW-1:0] m_id;
  bit             m_err;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_rr    = NP - 1;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] req, input logic [NP*RW-1:0] d,
                               input logic [NP*TW-1:0] t, input logic rdy, input logic rv,
                               input logic [IDW-1:0] rid, input logic [RTW-1:0] rdata);
    data_req                 = req;
    data                     = d;
    tid                      = t;
    bus.mem_req_ready_i      = rdy;
    bus.mem_rtrn_valid_i     = rv;
    bus.mem_rtrn_id_i        = rid;
    bus.mem_rtrn_data_i      = rdata;
  endtask

  task automatic checkRegs();
    checkOutput("req_valid", 64'(bus.mem_req_valid_o), 64'(m_valid));
    if (m_valid) begin
      checkOutput("req_data", 64'(bus.mem_req_data_o), 64'(m_data));
      checkOutput("req_id", 64'(bus.mem_req_id_o), 64'(m_id));
    end
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("idle%0d", p), 64'(port_idle[p]), 64'(m_cnt[p] == 0));
    end
    checkOutput("err", 64'(err), 64'(m_err));
  endtask

  // Called right after inputs are driven (at the falling edge). Checks the
  // combinational outputs, clocks once, advances the model, checks state.
  task automatic stepCycle();
    int            g;
    int            rp;
    bit            good;
    logic [NP-1:0] eack;
    logic [NP-1:0] evld;
    #1;
    g = -1;
    if (!m_valid || bus.mem_req_ready_i) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_rr + k) % NP;
        if (data_req[p] && m_cnt[p] < MAXO) begin
          g = p;
          break;
        end
      end
    end
    rp   = int'(bus.mem_rtrn_id_i >> TW);
    good = bus.mem_rtrn_valid_i && rp < NP && m_cnt[rp] > 0;
    eack = (g >= 0) ? (NP'(1) << g) : '0;
    evld = good ? (NP'(1) << rp) : '0;
    checkOutput("ack", 64'(data_ack), 64'(eack));
    checkOutput("rtrn_vld", 64'(rtrn_vld), 64'(evld));
    if (good) begin
      checkOutput("rtrn_data", 64'(rtrn), 64'(bus.mem_rtrn_data_i));
      checkOutput("rtrn_tid", 64'(rtrn_tid), 64'(bus.mem_rtrn_id_i[TW-1:0]));
    end
    @(posedge clk);
    if (g >= 0) begin
      m_cnt[g]++;
      m_rr    = g;
      m_valid = 1'b1;
      m_data  = data[g*RW +: RW];
      m_id    = {IDXW'(g), tid[g*TW +: TW]};
    end else if (bus.mem_req_ready_i) begin
      m_valid = 1'b0;
    end
    if (good) m_cnt[rp]--;
    if (bus.mem_rtrn_valid_i && !good) m_err = 1'b1;
    #1;
    checkRegs();
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must reach reset values without a clock edge.
  task automatic doReset();
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_ack", 64'(data_ack), 64'(0));
    checkOutput("rst_rtrn_vld", 64'(rtrn_vld), 64'(0));
    checkOutput("rst_req_valid", 64'(bus.mem_req_valid_o), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_idle", 64'(port_idle), 64'({NP{1'b1}}));
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [NP*RW-1:0] d;
    logic [NP*TW-1:0] t;
    logic [TW-1:0]    t0;
    logic [TW-1:0]    t2;
    logic [IDW-1:0]   rid;
    int               busy[$];

    rst_ni = 1'b1;
    applyStimulus('0, '0, '0, 1'b0, 1'b0, '0, '0);
    doReset();

    // Single request from port 1, tid 2, payload 0xA5.
    applyStimulus(3'b010, {16'h0000, 16'h00A5, 16'h0000}, {2'd0, 2'd2, 2'd0}, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("single_ack", 64'(data_ack), 64'(3'b010));
    stepCycle();
    checkOutput("single_valid", 64'(bus.mem_req_valid_o), 64'(1));
    checkOutput("single_id", 64'(bus.mem_req_id_o), 64'(4'b01_10));
    checkOutput("single_data", 64'(bus.mem_req_data_o), 64'(16'h00A5));
    checkOutput("single_idle1", 64'(port_idle[1]), 64'(0));
    applyStimulus('0, '0, '0, 1'b1, 1'b0, '0, '0);
    stepCycle();
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 4'b01_10, 16'h1234);
    #1;
    checkOutput("single_rtrn_vld", 64'(rtrn_vld), 64'(3'b010));
    checkOutput("single_rtrn_tid", 64'(rtrn_tid), 64'(2));
    stepCycle();

    // Round-robin with all ports requesting: grants 0,1,2,0,1,2.
    doReset();
    for (int c = 0; c < 6; c++) begin
      d = {16'($urandom), 16'($urandom), 16'($urandom)};
      t = 6'($urandom);
      applyStimulus(3'b111, d, t, 1'b1, 1'b0, '0, '0);
      #1;
      checkOutput("rr_ack", 64'(data_ack), 64'(NP'(1) << (c % NP)));
      stepCycle();
    end
    // Asynchronous reset mid-burst, requests still held high.
    #2;
    doReset();

    // Backpressure: one request latched, ready low for five cycles.
    t0 = 2'd3;
    t2 = 2'd1;
    applyStimulus(3'b001, {16'h0000, 16'h0000, 16'hBEEF}, {2'd0, 2'd0, t0}, 1'b1, 1'b0, '0, '0);
    stepCycle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(3'b100, {16'hCAFE, 16'h0000, 16'h0000}, {t2, 2'd0, 2'd0}, 1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("bp_no_ack", 64'(data_ack), 64'(0));
      stepCycle();
      checkOutput("bp_id", 64'(bus.mem_req_id_o), 64'({2'd0, t0}));
      checkOutput("bp_data", 64'(bus.mem_req_data_o), 64'(16'hBEEF));
    end
    applyStimulus(3'b100, {16'hCAFE, 16'h0000, 16'h0000}, {t2, 2'd0, 2'd0}, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("bp_drain_ack", 64'(data_ack), 64'(3'b100));
    stepCycle();
    checkOutput("bp_next_id", 64'(bus.mem_req_id_o), 64'({2'd2, t2}));

    // Credit limit on port 0.
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(3'b001, 48'(c), 6'd1, 1'b1, 1'b0, '0, '0);
      #1;
      checkOutput("credit_ack", 64'(data_ack), 64'((c < MAXO) ? 3'b001 : 3'b000));
      stepCycle();
    end
    applyStimulus(3'b001, 48'h7, 6'd1, 1'b1, 1'b1, 4'b00_01, 16'h5A5A);
    #1;
    checkOutput("credit_rtrn_vld", 64'(rtrn_vld), 64'(3'b001));
    checkOutput("credit_rtrn_tid", 64'(rtrn_tid), 64'(1));
    checkOutput("credit_no_bypass", 64'(data_ack), 64'(0));
    stepCycle();
    applyStimulus(3'b001, 48'h7, 6'd1, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("credit_freed_ack", 64'(data_ack), 64'(3'b001));
    stepCycle();

    // Simultaneous ack and return on port 0 with two outstanding.
    doReset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(3'b001, 48'(c), 6'd0, 1'b1, 1'b0, '0, '0);
      stepCycle();
    end
    applyStimulus(3'b001, 48'h9, 6'd0, 1'b1, 1'b1, 4'b00_00, 16'h1111);
    #1;
    checkOutput("simul_ack", 64'(data_ack), 64'(3'b001));
    checkOutput("simul_vld", 64'(rtrn_vld), 64'(3'b001));
    stepCycle();
    checkOutput("simul_idle0", 64'(port_idle[0]), 64'(0));
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 4'b00_00, 16'h2222);
    stepCycle();
    checkOutput("simul_idle0_one_left", 64'(port_idle[0]), 64'(0));
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 4'b00_00, 16'h3333);
    stepCycle();
    checkOutput("simul_idle0_drained", 64'(port_idle[0]), 64'(1));

    // Spurious returns: idle port 1, then nonexistent port 3.
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 4'b01_00, 16'h4444);
    #1;
    checkOutput("spur_no_vld", 64'(rtrn_vld), 64'(0));
    stepCycle();
    checkOutput("spur_err", 64'(err), 64'(1));
    applyStimulus('0, '0, '0, 1'b1, 1'b0, '0, '0);
    stepCycle();
    checkOutput("spur_err_sticky", 64'(err), 64'(1));
    applyStimulus('0, '0, '0, 1'b1, 1'b1, 4'b11_01, 16'h5555);
    #1;
    checkOutput("spur_range_no_vld", 64'(rtrn_vld), 64'(0));
    stepCycle();
    doReset();

    // Randomized traffic; returns mostly target ports with credits in use.
    for (int c = 0; c < 400; c++) begin
      d = {16'($urandom), 16'($urandom), 16'($urandom)};
      t = 6'($urandom);
      busy.delete();
      for (int p = 0; p < NP; p++) if (m_cnt[p] > 0) busy.push_back(p);
      if ($urandom_range(0, 19) == 0) begin
        rid = IDW'($urandom);
        applyStimulus(3'($urandom), d, t, 1'($urandom_range(0, 3) != 0), 1'b1, rid, 16'($urandom));
      end else if (busy.size() > 0 && $urandom_range(0, 1) == 1) begin
        rid = {IDXW'(busy[$urandom_range(0, busy.size() - 1)]), TW'($urandom)};
        applyStimulus(3'($urandom), d, t, 1'($urandom_range(0, 3) != 0), 1'b1, rid, 16'($urandom));
      end else begin
        applyStimulus(3'($urandom), d, t, 1'($urandom_range(0, 3) != 0), 1'b0, '0, '0);
      end
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
